// File: rtl/timer_tick_master.sv
// Bus initiator that programs a memory-mapped timer for a drift-free periodic tick.
// Each new compare is derived from the previous target, never from the time the ack lands.
module timer_tick_master #(
    parameter int width   = 64,
    parameter int CNT_W   = 16,
    parameter int MIN_PER = 4,
    parameter logic [width-1:0] TIMER_CNT_ADDR = width'(32'h1000_0000),
    parameter logic [width-1:0] TIMER_CRL_ADDR = width'(32'h1000_0008)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [width-1:0] period_in,
    input  logic             bus_grant,
    input  logic [width-1:0] cycle_in,
    input  logic             irq_in,
    output logic             bus_req,
    output logic [width-1:0] address,
    output logic [width-1:0] data,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic [CNT_W-1:0] missed_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_CNT   = 3'd1,
        WR_CMP   = 3'd2,
        WAIT_IRQ = 3'd3,
        WR_ACK   = 3'd4,
        DISARM   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [width-1:0] target_q, target_d;
    logic [width-1:0] period_q, period_d;
    logic [width-1:0] now_q;
    logic [CNT_W-1:0] tick_count_q, tick_count_d;
    logic [CNT_W-1:0] missed_q, missed_d;
    logic [width-1:0] period_clamped;
    logic             target_valid;

    function automatic logic [width-1:0] clamp_period(input logic [width-1:0] p);
        return (p < width'(MIN_PER)) ? width'(MIN_PER) : p;
    endfunction

    // Target must lie strictly ahead of the shadow count, within half the count range.
    function automatic logic is_ahead(input logic [width-1:0] tgt, input logic [width-1:0] now);
        logic [width-1:0] diff;
        diff = tgt - now;
        return (diff != '0) && !diff[width-1];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign period_clamped = clamp_period(period_in);
    assign target_valid   = is_ahead(target_q, now_q);

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        period_d     = period_q;
        tick_count_d = tick_count_q;
        missed_d     = missed_q;
        bus_req      = 1'b0;
        address      = '0;
        data         = '0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        tick         = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = RD_CNT;
            end
            RD_CNT: begin
                bus_req = 1'b1;
                if (bus_grant) begin
                    MemRead = 1'b1;
                    address = TIMER_CNT_ADDR;
                end
                if (!enable) begin
                    state_d = IDLE;
                end else if (bus_grant) begin
                    period_d = period_clamped;
                    target_d = cycle_in + period_clamped;
                    state_d  = WR_CMP;
                end
            end
            WR_CMP: begin
                bus_req = 1'b1;
                if (!enable) begin
                    state_d = DISARM;
                end else if (!target_valid) begin
                    // Target already passed: skip whole periods to stay on the original grid.
                    target_d = target_q + period_q;
                    missed_d = sat_inc(missed_q);
                end else if (bus_grant) begin
                    MemWrite = 1'b1;
                    address  = TIMER_CNT_ADDR;
                    data     = target_q;
                    state_d  = WAIT_IRQ;
                end
            end
            WAIT_IRQ: begin
                if (irq_in) begin
                    tick         = 1'b1;
                    tick_count_d = tick_count_q + CNT_W'(1);
                    state_d      = WR_ACK;
                end else if (!enable) begin
                    state_d = DISARM;
                end
            end
            WR_ACK: begin
                bus_req = 1'b1;
                if (bus_grant) begin
                    MemWrite = 1'b1;
                    address  = TIMER_CRL_ADDR;
                    if (enable) begin
                        period_d = period_clamped;
                        target_d = target_q + period_clamped;
                        state_d  = WR_CMP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DISARM: begin
                bus_req = 1'b1;
                if (bus_grant) begin
                    MemWrite = 1'b1;
                    address  = TIMER_CRL_ADDR;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            target_q     <= '0;
            period_q     <= '0;
            now_q        <= '0;
            tick_count_q <= '0;
            missed_q     <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            period_q     <= period_d;
            tick_count_q <= tick_count_d;
            missed_q     <= missed_d;
            // Shadow of the timer: the sampled count is one cycle old by the next edge.
            if (state_q == RD_CNT && bus_grant) now_q <= cycle_in + width'(1);
            else                                now_q <= now_q + width'(1);
        end
    end

    assign tick_count   = tick_count_q;
    assign missed_count = missed_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_timer_tick_master.sv
// Randomized and directed bench for timer_tick_master with an in-bench timer peripheral
// and a reference model of the tick scheduler.
module tb_timer_tick_master;

    localparam logic [63:0] CNT_ADDR = 64'h0000_0000_1000_0000;
    localparam logic [63:0] CRL_ADDR = 64'h0000_0000_1000_0008;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [63:0] period_in;
    logic        bus_grant;
    logic [63:0] cycle_in;
    logic        irq_in;
    logic        bus_req;
    logic [63:0] address;
    logic [63:0] data;
    logic        MemRead;
    logic        MemWrite;
    logic        tick;
    logic [15:0] tick_count;
    logic [15:0] missed_count;
    logic        busy;

    timer_tick_master #(
        .width(64), .CNT_W(16), .MIN_PER(4),
        .TIMER_CNT_ADDR(CNT_ADDR), .TIMER_CRL_ADDR(CRL_ADDR)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .period_in(period_in),
        .bus_grant(bus_grant), .cycle_in(cycle_in), .irq_in(irq_in),
        .bus_req(bus_req), .address(address), .data(data), .MemRead(MemRead),
        .MemWrite(MemWrite), .tick(tick), .tick_count(tick_count),
        .missed_count(missed_count), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // stimulus knobs
    logic        rstn_v, g_v, en_v, spur_v;
    logic [63:0] per_v;

    // reference model: 0 idle, 1 read count, 2 write compare, 3 wait irq, 4 ack, 5 disarm
    int          m_st;
    logic [63:0] m_target, m_now, m_period;
    logic [15:0] m_ticks, m_missed;

    // timer peripheral
    logic [63:0] tcount, t_cmp;
    logic        t_armed, t_irq;

    // outputs observed in the most recent cycle
    logic        cap_mw, cap_mr, cap_tick, cap_busy;
    logic [63:0] cap_addr, cap_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_st = 0; m_target = '0; m_now = '0; m_period = '0; m_ticks = '0; m_missed = '0;
    endtask

    function automatic logic [63:0] clampp(input logic [63:0] p);
        return (p < 64'd4) ? 64'd4 : p;
    endfunction

    task automatic step();
        logic [63:0] diff, e_addr, e_data;
        logic        ahead, e_req, e_rd, e_cmpw, e_wr, e_tick, match;
        int          n_st;
        @(posedge clock);
        #1;
        reset_n   = rstn_v;
        bus_grant = g_v;
        enable    = en_v;
        period_in = per_v;
        cycle_in  = tcount;
        irq_in    = t_irq | spur_v;
        @(negedge clock);
        diff   = m_target - m_now;
        ahead  = (diff != 0) && (diff < 64'h8000_0000_0000_0000);
        e_req  = (m_st == 1) || (m_st == 2) || (m_st == 4) || (m_st == 5);
        e_rd   = bus_grant && m_st == 1;
        e_cmpw = bus_grant && m_st == 2 && enable && ahead;
        e_wr   = e_cmpw || (bus_grant && (m_st == 4 || m_st == 5));
        e_addr = (e_rd || e_cmpw) ? CNT_ADDR : (e_wr ? CRL_ADDR : 64'd0);
        e_data = e_cmpw ? m_target : 64'd0;
        e_tick = (m_st == 3) && irq_in;
        cap_mw = MemWrite; cap_mr = MemRead; cap_tick = tick; cap_busy = busy;
        cap_addr = address; cap_data = data;
        check("bus_req", 64'(bus_req), 64'(e_req));
        check("MemRead", 64'(MemRead), 64'(e_rd));
        check("MemWrite", 64'(MemWrite), 64'(e_wr));
        check("address", address, e_addr);
        check("data", data, e_data);
        check("tick", 64'(tick), 64'(e_tick));
        check("tick_count", 64'(tick_count), 64'(m_ticks));
        check("missed_count", 64'(missed_count), 64'(m_missed));
        check("busy", 64'(busy), 64'(m_st != 0));
        // advance the model to the state the coming edge produces
        if (!reset_n) begin
            model_reset();
        end else begin
            n_st = m_st;
            case (m_st)
                0: if (enable) n_st = 1;
                1: if (!enable) n_st = 0;
                   else if (bus_grant) begin
                       m_period = clampp(period_in);
                       m_target = cycle_in + m_period;
                       n_st = 2;
                   end
                2: if (!enable) n_st = 5;
                   else if (!ahead) begin
                       m_target = m_target + m_period;
                       if (m_missed != 16'hFFFF) m_missed = m_missed + 1;
                   end else if (bus_grant) n_st = 3;
                3: if (irq_in) begin m_ticks = m_ticks + 1; n_st = 4; end
                   else if (!enable) n_st = 5;
                4: if (bus_grant) begin
                       if (enable) begin
                           m_period = clampp(period_in);
                           m_target = m_target + m_period;
                           n_st = 2;
                       end else n_st = 0;
                   end
                5: if (bus_grant) n_st = 0;
                default: n_st = 0;
            endcase
            if (m_st == 1 && bus_grant) m_now = cycle_in + 1;
            else                        m_now = m_now + 1;
            m_st = n_st;
        end
        // timer: irq rises the cycle after count equals compare, holds until cleared
        match = t_armed && (tcount == t_cmp);
        if (match) t_irq = 1'b1;
        if (e_wr && e_addr == CNT_ADDR) begin
            t_cmp = e_data; t_armed = 1'b1; t_irq = 1'b0;
        end else if (e_wr && e_addr == CRL_ADDR) begin
            t_armed = 1'b0; t_irq = 1'b0;
        end
        tcount = tcount + 1;
    endtask

    task automatic run_until_state(input int st, input string name);
        int n;
        n = 0;
        while (m_st != st && n < 500) begin step(); n++; end
        if (m_st != st) timeout(name);
    endtask

    task automatic run_until_write(input string name);
        int n;
        n = 0;
        do begin step(); n++; end
        while (!(cap_mw && cap_addr == CNT_ADDR) && n < 1000);
        if (!(cap_mw && cap_addr == CNT_ADDR)) timeout(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        reset_n = 1'b0; enable = 1'b0; period_in = '0; bus_grant = 1'b0;
        cycle_in = '0; irq_in = 1'b0;
        rstn_v = 1'b0; g_v = 1'b0; en_v = 1'b0; spur_v = 1'b0; per_v = 64'd100;
        tcount = 64'd0; t_cmp = '0; t_armed = 1'b0; t_irq = 1'b0;
        model_reset();
        repeat (3) step();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_tick_count", 64'(tick_count), 64'd0);

        // basic periodic run, period 100 from count 1000
        rstn_v = 1'b1; g_v = 1'b1; en_v = 1'b1; per_v = 64'd100;
        run_until_state(1, "reach_rd_cnt");
        tcount = 64'd1000;
        step();
        check("rd_memread", 64'(cap_mr), 64'd1);
        check("rd_address", cap_addr, CNT_ADDR);
        step();
        check("first_cmp_memwrite", 64'(cap_mw), 64'd1);
        check("first_cmp_address", cap_addr, CNT_ADDR);
        check("first_cmp_data", cap_data, 64'd1100);
        run_until_write("second_cmp");
        check("second_cmp_data", cap_data, 64'd1200);
        check("ticks_after_1", 64'(tick_count), 64'd1);
        run_until_write("third_cmp");
        check("third_cmp_data", cap_data, 64'd1300);
        check("ticks_after_2", 64'(tick_count), 64'd2);
        run_until_write("fourth_cmp");
        check("fourth_cmp_data", cap_data, 64'd1400);
        check("ticks_after_3", 64'(tick_count), 64'd3);

        // period below minimum is clamped
        en_v = 1'b0;
        run_until_state(0, "idle_before_clamp");
        per_v = 64'd1; en_v = 1'b1;
        run_until_state(1, "rd_for_clamp");
        tcount = 64'd5000;
        step();
        step();
        check("clamp_memwrite", 64'(cap_mw), 64'd1);
        check("clamp_first_data", cap_data, 64'd5004);
        run_until_write("clamp_second");
        check("clamp_second_data", cap_data, 64'd5008);

        // long grant outage in WR_CMP skips passed targets
        en_v = 1'b0;
        run_until_state(0, "idle_before_miss");
        per_v = 64'd100; en_v = 1'b1;
        run_until_state(1, "rd_for_miss");
        tcount = 64'd20000;
        step();
        g_v = 1'b0;
        repeat (250) step();
        g_v = 1'b1;
        run_until_write("write_after_outage");
        check("missed_count_outage", 64'(missed_count), 64'd2);
        check("outage_target", cap_data, 64'd20300);

        // disable while waiting: disarm then idle, stray irq ignored
        en_v = 1'b0;
        step();
        step();
        check("disarm_memwrite", 64'(cap_mw), 64'd1);
        check("disarm_address", cap_addr, CRL_ADDR);
        check("disarm_data", cap_data, 64'd0);
        step();
        check("idle_after_disarm", 64'(cap_busy), 64'd0);
        spur_v = 1'b1;
        repeat (3) begin
            step();
            check("stray_irq_no_tick", 64'(cap_tick), 64'd0);
        end
        spur_v = 1'b0;

        // target wraps past the top of the count range
        per_v = 64'd10; en_v = 1'b1;
        run_until_state(1, "rd_for_wrap");
        tcount = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        step();
        check("wrap_memwrite", 64'(cap_mw), 64'd1);
        check("wrap_data", cap_data, 64'd8);

        // asynchronous reset while waiting for the interrupt
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_bus_req", 64'(bus_req), 64'd0);
        check("async_rst_tick_count", 64'(tick_count), 64'd0);
        check("async_rst_missed", 64'(missed_count), 64'd0);
        check("async_rst_address", address, 64'd0);
        model_reset();
        t_armed = 1'b0; t_irq = 1'b0;
        rstn_v = 1'b0; en_v = 1'b0;
        repeat (2) step();
        rstn_v = 1'b1;
        repeat (5) begin
            step();
            check("busy_after_release", 64'(cap_busy), 64'd0);
        end

        // randomized traffic
        gap = 0;
        en_v = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (gap > 0) begin
                g_v = 1'b0;
                gap--;
            end else begin
                g_v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 199) == 0) gap = $urandom_range(20, 90);
            end
            if (en_v && $urandom_range(0, 399) == 0) en_v = 1'b0;
            else if (!en_v && $urandom_range(0, 19) == 0) en_v = 1'b1;
            per_v  = 64'($urandom_range(0, 40));
            spur_v = ($urandom_range(0, 40) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
